// File: rtl/reg_dump_tx.sv
// Register-file dump streamer: walks debug addresses 0..NREGS-1 and sends each
// captured word MSB-byte-first over a valid/ready byte interface.
module reg_dump_tx #(
  parameter int unsigned NBITS = 32,
  parameter int unsigned REGS  = 5,
  parameter int unsigned NREGS = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  output logic [REGS-1:0]  o_dir_debug,
  input  logic [NBITS-1:0] i_data_debug,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_busy,
  output logic             o_done
);

  localparam int unsigned NBYTES = NBITS / 8;
  localparam int unsigned BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned RW     = $clog2(NREGS + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

  state_t           r_state,    w_state_nxt;
  logic [RW-1:0]    r_reg_idx,  w_reg_idx_nxt;
  logic [BW-1:0]    r_byte_idx, w_byte_idx_nxt;
  logic [NBITS-1:0] r_shift,    w_shift_nxt;
  logic [REGS-1:0]  r_dir,      w_dir_nxt;
  logic [7:0]       r_tx_data,  w_tx_data_nxt;
  logic             r_tx_valid, w_tx_valid_nxt;
  logic             r_busy,     w_busy_nxt;
  logic             r_done,     w_done_nxt;
  logic [RW-1:0]    w_reg_inc;

  assign w_reg_inc = r_reg_idx + RW'(1);

  // State and output registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_reg_idx  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_dir      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_reg_idx  <= w_reg_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_dir      <= w_dir_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_reg_idx_nxt  = r_reg_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_shift_nxt    = r_shift;
    w_dir_nxt      = r_dir;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt   = S_LOAD;
          w_busy_nxt    = 1'b1;
          w_reg_idx_nxt = '0;
          w_dir_nxt     = '0;
        end
      end
      S_LOAD: begin
        // Shift register keeps the bytes still to be sent, top-aligned
        w_shift_nxt    = i_data_debug << 8;
        w_byte_idx_nxt = '0;
        w_tx_data_nxt  = i_data_debug[NBITS-1 -: 8];
        w_tx_valid_nxt = 1'b1;
        w_state_nxt    = S_SEND;
      end
      S_SEND: begin
        if (r_tx_valid && i_tx_ready) begin
          if (r_byte_idx == BW'(NBYTES - 1)) begin
            w_tx_valid_nxt = 1'b0;
            if (r_reg_idx == RW'(NREGS - 1)) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_reg_idx_nxt = w_reg_inc;
              w_dir_nxt     = REGS'(w_reg_inc);
              w_state_nxt   = S_LOAD;
            end
          end else begin
            w_tx_data_nxt  = r_shift[NBITS-1 -: 8];
            w_shift_nxt    = r_shift << 8;
            w_byte_idx_nxt = r_byte_idx + BW'(1);
          end
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_dir_debug = r_dir;
  assign o_tx_data   = r_tx_data;
  assign o_tx_valid  = r_tx_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Bench for reg_dump_tx: scoreboarded byte streams under several ready patterns,
// ignored start, async reset mid-dump and a 4-register instance.
module tb_reg_dump_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic        ready = 1'b1;
  logic [4:0]  dir, dir4;
  logic [31:0] data, data4;
  logic [7:0]  tx_data, tx_data4;
  logic        tx_valid, tx_valid4, busy, busy4, done, done4;

  always #5 clk = ~clk;

  // Register-file models: r[k] = base + k
  assign data  = 32'h11223300 + 32'(dir);
  assign data4 = 32'hA0B0C000 + 32'(dir4);

  reg_dump_tx u_dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .o_dir_debug(dir),
    .i_data_debug(data), .o_tx_data(tx_data), .o_tx_valid(tx_valid),
    .i_tx_ready(ready), .o_busy(busy), .o_done(done)
  );

  reg_dump_tx #(.NBITS(32), .REGS(5), .NREGS(4)) u_dut4 (
    .i_clk(clk), .i_reset(rst_n), .i_start(start4), .o_dir_debug(dir4),
    .i_data_debug(data4), .o_tx_data(tx_data4), .o_tx_valid(tx_valid4),
    .i_tx_ready(ready), .o_busy(busy4), .o_done(done4)
  );

  typedef struct {
    int pct;
    int glitch_at;
    int exp_done;
  } vec_t;

  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         nbytes = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_dump();
    logic [31:0] w;
    for (int k = 0; k < 32; k++) begin
      w = 32'h11223300 + 32'(k);
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (8 * (3 - b))));
    end
  endtask

  // Called once per negedge: stability under backpressure and scoreboard pop
  task automatic mon_step();
    logic [7:0] e;
    if (prev_hold) begin
      check("hold_valid", tx_valid, 1);
      check("hold_data", tx_data, prev_data);
    end
    if (tx_valid && ready) begin
      nbytes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_byte actual=%0h required=none", tx_data);
      end else begin
        e = exp_q.pop_front();
        check("byte", tx_data, e);
      end
    end
    prev_hold = tx_valid && !ready;
    prev_data = tx_data;
  endtask

  task automatic run_dump(input int pct, input int glitch_at, output int done_cyc);
    int  cyc;
    int  nb0;
    bit  pulsed;
    pulsed    = 1'b0;
    prev_hold = 1'b0;
    nb0       = nbytes;
    done_cyc  = -1;
    push_dump();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (cyc < 5000) begin
      ready = ($urandom_range(99) < pct);
      if (!pulsed && glitch_at >= 0 && (nbytes - nb0) >= glitch_at) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      mon_step();
      if (done) begin
        done_cyc = cyc;
        break;
      end
      check("busy_during", busy, 1);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    ready = 1'b1;
    if (done_cyc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=none required=o_done");
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("post_valid", tx_valid, 0);
    end
    check("queue_empty", exp_q.size(), 0);
    check("byte_count", nbytes - nb0, 128);
  endtask

  initial begin
    vec_t vecs[4];
    int   dc;
    int   cyc;
    int   cnt;
    bit   found;
    logic [31:0] w;

    vecs[0] = '{pct: 100, glitch_at: -1, exp_done: 161};
    vecs[1] = '{pct: 50,  glitch_at: -1, exp_done: -1};
    vecs[2] = '{pct: 100, glitch_at: 40, exp_done: 161};
    vecs[3] = '{pct: 30,  glitch_at: 40, exp_done: -1};

    // Asynchronous reset forces all outputs low
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", tx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dir", dir, 0);
    check("rst_data", tx_data, 0);
    check("rst_busy4", busy4, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_valid", tx_valid, 0);
    @(posedge clk); #1;

    for (int v = 0; v < 4; v++) begin
      run_dump(vecs[v].pct, vecs[v].glitch_at, dc);
      if (vecs[v].exp_done >= 0) check("done_cycle", dc, vecs[v].exp_done);
      else check("done_seen", dc > 0, 1);
      @(posedge clk); #1;
    end

    // Reset while r7 byte 2 is on the bus
    prev_hold = 1'b0;
    push_dump();
    ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      mon_step();
      if (tx_valid && dir == 5'd7 && tx_data == 8'h33) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("r7_b2_reached", found, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_dir", dir, 0);
    check("abort_data", tx_data, 0);
    exp_q.delete();
    prev_hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_dump(100, -1, dc);
    check("restart_done_cycle", dc, 161);
    @(posedge clk); #1;

    // Four-register instance, ready held high
    ready  = 1'b1;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 1;
    cnt = 0;
    dc  = -1;
    while (cyc < 200) begin
      @(negedge clk);
      if (tx_valid4 && ready) begin
        w = 32'hA0B0C000 + 32'(cnt / 4);
        check("byte4", tx_data4, 8'(w >> (8 * (3 - (cnt % 4)))));
        cnt++;
      end
      if (done4) begin
        dc = cyc;
        break;
      end
      check("busy4_during", busy4, 1);
      @(posedge clk); #1;
      cyc++;
    end
    check("done4_cycle", dc, 21);
    check("byte4_count", cnt, 16);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_busy4", busy4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
